key_expansion: RTL and testbench

Sequential AES-128 key schedule generator. It accepts a 128-bit cipher key and produces all eleven round keys, one round key per clock. The results go into the 1408-bit packed schedule that the round-key XOR stage selects from by round number. It sits between the key register and the cipher datapath, and its handshake gates the start of encryption/decryption.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_sbox.sv | 31 +++
 rtl/key_expansion.sv | 103 ++++++++++
 tb/tb_key_expansion.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: widths, round constants and key FSM states.
// Imported by the key schedule generator and the S-box.
package aes_pkg;

  localparam int RK_W       = 128;
  localparam int SCHED_W    = 1408;
  localparam int NUM_ROUNDS = 10;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_EXPAND,
    KS_DONE
  } ks_state_e;

  // Round constant table, indexed by round 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational 256-entry byte lookup.
// Ports: byte_i input byte, byte_o substituted byte.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Entry 0 sits in the top byte of the table.
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Top bit of entry x is 2047 - 8x, i.e. {~x, 3'b111}.
  assign byte_o = TBL[{~byte_i, 3'b111} -: 8];

endmodule

// File: rtl/key_expansion.sv
// Sequential AES-128 key schedule: one round key per clock into a packed schedule.
// Ports: Clk, Reset, Start, Cipher_Key in; Key_Schedule, Busy, Done, Valid out.
module key_expansion
  import aes_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [RK_W-1:0]    Cipher_Key,
  output logic [SCHED_W-1:0] Key_Schedule,
  output logic               Busy,
  output logic               Done,
  output logic               Valid
);

  ks_state_e          state_q;
  logic [3:0]         cnt_q;
  logic [SCHED_W-1:0] sched_q;
  logic               busy_q;
  logic               done_q;
  logic               valid_q;

  logic [3:0]      prev_idx;
  logic [RK_W-1:0] prev_rk;
  logic [RK_W-1:0] next_rk;
  logic [31:0]     w0, w1, w2, w3;
  logic [31:0]     rot, sub, t;
  logic [31:0]     n0, n1, n2, n3;

  // Clamp keeps the read slot in range while idle (counter 0).
  assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign prev_rk  = sched_q[{prev_idx, 7'd0} +: RK_W];

  assign w0 = prev_rk[127:96];
  assign w1 = prev_rk[95:64];
  assign w2 = prev_rk[63:32];
  assign w3 = prev_rk[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  aes_sbox u_sb0 (.byte_i(rot[31:24]), .byte_o(sub[31:24]));
  aes_sbox u_sb1 (.byte_i(rot[23:16]), .byte_o(sub[23:16]));
  aes_sbox u_sb2 (.byte_i(rot[15:8]),  .byte_o(sub[15:8]));
  aes_sbox u_sb3 (.byte_i(rot[7:0]),   .byte_o(sub[7:0]));

  assign t  = sub ^ {rcon(cnt_q), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_rk = {n0, n1, n2, n3};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= KS_IDLE;
      cnt_q   <= 4'd0;
      sched_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        KS_IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            sched_q[RK_W-1:0] <= Cipher_Key;
            cnt_q   <= 4'd1;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= KS_EXPAND;
          end
        end
        KS_EXPAND: begin
          sched_q[{cnt_q, 7'd0} +: RK_W] <= next_rk;
          if (cnt_q == LAST_ROUND) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= KS_DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        KS_DONE: begin
          done_q  <= 1'b0;
          state_q <= KS_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= KS_IDLE;
        end
      endcase
    end
  end

  assign Key_Schedule = sched_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Valid        = valid_q;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion.
// Reference schedule built from a GF(2^8) S-box and xtime Rcon chain.
module tb_key_expansion;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [127:0]  Cipher_Key;
  logic [1407:0] Key_Schedule;
  logic          Busy;
  logic          Done;
  logic          Valid;

  key_expansion dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Cipher_Key(Cipher_Key),
    .Key_Schedule(Key_Schedule),
    .Busy(Busy),
    .Done(Done),
    .Valid(Valid)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [7:0]    sbm [0:255];
  logic [1407:0] sb_q [$];

  typedef struct {
    logic [127:0] key;
    logic [127:0] exp1;
    logic [127:0] exp10;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbm[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] model(input logic [127:0] k);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] s;
    w[0] = k[127:96];
    w[1] = k[95:64];
    w[2] = k[63:32];
    w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]], sbm[t[31:24]]};
        t = t ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      s[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  function automatic logic [127:0] slot(input logic [1407:0] s, input int r);
    return s[128*r +: 128];
  endfunction

  function automatic logic [127:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_sched(input string name, input logic [1407:0] act, input logic [1407:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int r = 0; r < 11; r++)
        if (slot(act, r) !== slot(exp, r)) begin
          $display("FAIL %s slot %0d: got %h required %h", name, r, slot(act, r), slot(exp, r));
          break;
        end
    end
  endtask

  // Scoreboard: each Done retires the oldest accepted key.
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got Done=1 required no pending expansion");
      end else begin
        chk_sched("sched_at_done", Key_Schedule, sb_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic accept(input logic [127:0] k);
    Start = 1'b1;
    Cipher_Key = k;
    @(posedge Clk);
    sb_q.push_back(model(k));
    @(negedge Clk);
    Start = 1'b0;
    chk("busy_after_accept", Busy, 1);
    chk("valid_drop_on_accept", Valid, 0);
    chk("slot0_after_accept", slot(Key_Schedule, 0), k);
  endtask

  task automatic run_full(input string name, input logic [127:0] k,
                          input logic [127:0] e1, input logic [127:0] e10);
    int d0;
    int k_at;
    d0 = done_cnt;
    k_at = -1;
    accept(k);
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      if (c == 3) Cipher_Key = ~k;
      if (Done && k_at < 0) k_at = c;
    end
    chk({name, "_done_cycle"}, 128'(k_at), 10);
    chk({name, "_done_count"}, 128'(done_cnt - d0), 1);
    chk({name, "_valid"}, Valid, 1);
    chk({name, "_busy_end"}, Busy, 0);
    chk({name, "_slot1"}, slot(Key_Schedule, 1), e1);
    chk({name, "_slot10"}, slot(Key_Schedule, 10), e10);
  endtask

  initial begin
    int d0;
    int k_at;
    int dones [$];
    logic [127:0] ka;
    logic [127:0] kb;

    Reset = 1'b1;
    Start = 1'b0;
    Cipher_Key = '0;
    build_sbox();

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    for (int i = 2; i < 4; i++) begin
      vecs[i].key   = rkey();
      vecs[i].exp1  = slot(model(vecs[i].key), 1);
      vecs[i].exp10 = slot(model(vecs[i].key), 10);
    end

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      Cipher_Key = rkey();
      @(negedge Clk);
      chk("idle_flags", {Busy, Done, Valid}, 0);
      chk_sched("idle_sched", Key_Schedule, '0);
    end

    for (int i = 0; i < 4; i++)
      run_full($sformatf("vec%0d", i), vecs[i].key, vecs[i].exp1, vecs[i].exp10);

    // Start pulses during EXPAND and DONE must be ignored.
    ka = vecs[0].key;
    d0 = done_cnt;
    k_at = -1;
    accept(ka);
    for (int c = 1; c <= 14; c++) begin
      Start = (c == 3 || c == 11);
      if (Start) Cipher_Key = rkey();
      @(negedge Clk);
      if (Done && k_at < 0) k_at = c;
    end
    Start = 1'b0;
    chk("ign_done_cycle", 128'(k_at), 10);
    chk("ign_done_count", 128'(done_cnt - d0), 1);
    chk("ign_no_restart", Busy, 0);
    chk_sched("ign_sched", Key_Schedule, model(ka));

    // Reset mid-expansion abandons the run.
    accept(rkey());
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("rst_flags", {Busy, Done, Valid}, 0);
    chk_sched("rst_sched", Key_Schedule, '0);
    sb_q.delete();
    d0 = done_cnt;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (12) @(negedge Clk);
    chk("rst_no_done", 128'(done_cnt - d0), 0);
    ka = rkey();
    run_full("post_rst", ka, slot(model(ka), 1), slot(model(ka), 10));

    // Start held high: accepted every 12 cycles.
    ka = rkey();
    kb = rkey();
    d0 = done_cnt;
    Start = 1'b1;
    Cipher_Key = ka;
    @(posedge Clk);
    sb_q.push_back(model(ka));
    @(negedge Clk);
    Cipher_Key = kb;
    for (int c = 1; c <= 24; c++) begin
      @(negedge Clk);
      if (Done) dones.push_back(c);
      if (c == 11) begin
        chk("b2b_valid_before", Valid, 1);
        chk("b2b_idle_before", {Busy, Done}, 0);
      end
      if (c == 12) begin
        sb_q.push_back(model(kb));
        Start = 1'b0;
        chk("b2b_busy_accept", Busy, 1);
        chk("b2b_valid_drop", Valid, 0);
        chk("b2b_slot0", slot(Key_Schedule, 0), kb);
      end
    end
    chk("b2b_done_count", 128'(done_cnt - d0), 2);
    chk("b2b_done_a", 128'(dones.size() > 0 ? dones[0] : -1), 10);
    chk("b2b_done_b", 128'(dones.size() > 1 ? dones[1] : -1), 22);
    chk("b2b_valid_end", Valid, 1);
    chk_sched("b2b_sched_b", Key_Schedule, model(kb));
    chk("sb_empty", 128'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

endmodule
